// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment frame decoder: state encoding,
// character codes and segment patterns (bit order a b c d e f g1 g2 h i j k l m, MSB first).
package seg14_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam logic [5:0] CODE_SPACE   = 6'd0;
    localparam logic [5:0] CODE_A       = 6'd1;
    localparam logic [5:0] CODE_NTILDE  = 6'd27;
    localparam logic [5:0] CODE_DIGIT0  = 6'd28;
    localparam logic [5:0] CODE_UNKNOWN = 6'd63;

    localparam logic [13:0] PAT_SPACE  = 14'b0000_0000_0000_00;
    localparam logic [13:0] PAT_A      = 14'b1110_1111_0000_00;
    localparam logic [13:0] PAT_B      = 14'b1111_0001_0100_10;
    localparam logic [13:0] PAT_C      = 14'b1001_1100_0000_00;
    localparam logic [13:0] PAT_D      = 14'b1111_0000_0100_10;
    localparam logic [13:0] PAT_E      = 14'b1001_1111_0000_00;
    localparam logic [13:0] PAT_F      = 14'b1000_1110_0000_00;
    localparam logic [13:0] PAT_G      = 14'b1011_1101_0000_00;
    localparam logic [13:0] PAT_H      = 14'b0110_1111_0000_00;
    localparam logic [13:0] PAT_I      = 14'b1001_0000_0100_10;
    localparam logic [13:0] PAT_J      = 14'b0111_1000_0000_00;
    localparam logic [13:0] PAT_K      = 14'b0000_1110_0010_01;
    localparam logic [13:0] PAT_L      = 14'b0001_1100_0000_00;
    localparam logic [13:0] PAT_M      = 14'b0110_1100_1010_00;
    localparam logic [13:0] PAT_N      = 14'b0110_1100_1000_01;
    localparam logic [13:0] PAT_O      = 14'b1111_1100_0000_00;
    localparam logic [13:0] PAT_P      = 14'b1100_1111_0000_00;
    localparam logic [13:0] PAT_Q      = 14'b1111_1100_0000_01;
    localparam logic [13:0] PAT_R      = 14'b1100_1111_0000_01;
    localparam logic [13:0] PAT_S      = 14'b1011_0111_0000_00;
    localparam logic [13:0] PAT_T      = 14'b1000_0000_0100_10;
    localparam logic [13:0] PAT_U      = 14'b0111_1100_0000_00;
    localparam logic [13:0] PAT_V      = 14'b0000_1100_0011_00;
    localparam logic [13:0] PAT_W      = 14'b0110_1100_0001_01;
    localparam logic [13:0] PAT_X      = 14'b0000_0000_1011_01;
    localparam logic [13:0] PAT_Y      = 14'b0000_0000_1010_10;
    localparam logic [13:0] PAT_Z      = 14'b1001_0000_0011_00;
    localparam logic [13:0] PAT_NTILDE = 14'b1110_1100_1000_01;
    // Digit 5 uses a diagonal stroke so it never aliases the plain S shape.
    localparam logic [13:0] PAT_D0     = 14'b1111_1100_0011_00;
    localparam logic [13:0] PAT_D1     = 14'b0110_0000_0010_00;
    localparam logic [13:0] PAT_D2     = 14'b1101_1011_0000_00;
    localparam logic [13:0] PAT_D3     = 14'b1111_0001_0000_00;
    localparam logic [13:0] PAT_D4     = 14'b0110_0111_0000_00;
    localparam logic [13:0] PAT_D5     = 14'b1001_0110_0000_01;
    localparam logic [13:0] PAT_D6     = 14'b1011_1111_0000_00;
    localparam logic [13:0] PAT_D7     = 14'b1110_0000_0000_00;
    localparam logic [13:0] PAT_D8     = 14'b1111_1111_0000_00;
    localparam logic [13:0] PAT_D9     = 14'b1111_0111_0000_00;

endpackage

// File: rtl/seg14_char_decode.sv
// Combinational 14-segment pattern to 6-bit character code lookup.
module seg14_char_decode
    import seg14_pkg::*;
(
    input  logic [13:0] segm,
    output logic [5:0]  code
);

    always_comb begin
        code = CODE_UNKNOWN;
        case (segm)
            PAT_SPACE:  code = CODE_SPACE;
            PAT_A:      code = CODE_A;
            PAT_B:      code = 6'd2;
            PAT_C:      code = 6'd3;
            PAT_D:      code = 6'd4;
            PAT_E:      code = 6'd5;
            PAT_F:      code = 6'd6;
            PAT_G:      code = 6'd7;
            PAT_H:      code = 6'd8;
            PAT_I:      code = 6'd9;
            PAT_J:      code = 6'd10;
            PAT_K:      code = 6'd11;
            PAT_L:      code = 6'd12;
            PAT_M:      code = 6'd13;
            PAT_N:      code = 6'd14;
            PAT_O:      code = 6'd15;
            PAT_P:      code = 6'd16;
            PAT_Q:      code = 6'd17;
            PAT_R:      code = 6'd18;
            PAT_S:      code = 6'd19;
            PAT_T:      code = 6'd20;
            PAT_U:      code = 6'd21;
            PAT_V:      code = 6'd22;
            PAT_W:      code = 6'd23;
            PAT_X:      code = 6'd24;
            PAT_Y:      code = 6'd25;
            PAT_Z:      code = 6'd26;
            PAT_NTILDE: code = CODE_NTILDE;
            PAT_D0:     code = CODE_DIGIT0;
            PAT_D1:     code = 6'd29;
            PAT_D2:     code = 6'd30;
            PAT_D3:     code = 6'd31;
            PAT_D4:     code = 6'd32;
            PAT_D5:     code = 6'd33;
            PAT_D6:     code = 6'd34;
            PAT_D7:     code = 6'd35;
            PAT_D8:     code = 6'd36;
            PAT_D9:     code = 6'd37;
            default:    code = CODE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg14_frame_decoder.sv
// Follows a one-hot 14-segment display scan, decodes each digit and commits
// complete 12-position frames into a readable output buffer.
module seg14_frame_decoder
    import seg14_pkg::*;
#(
    parameter int NPOS = 12
) (
`ifdef USE_POWER_PINS
    inout  wire              vdd,
    inout  wire              vss,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPOS-1:0]  sel,
    input  logic [13:0]      segm,
    input  logic [3:0]       rd_idx,
    output logic [5:0]       rd_code,
    input  logic             ack,
    output logic             frame_valid,
    output logic             frame_ovf,
    output logic             bad_char,
    output logic             seq_err,
    output logic             locked
);

    localparam logic [NPOS-1:0] FIRST_SEL = NPOS'(1);
    localparam logic [3:0]      LAST_POS  = 4'(NPOS - 1);

    logic [NPOS-1:0] sel_q;
    logic [13:0]     segm_q;
    logic [5:0]      char_code;
    logic            char_unknown;

    state_t          state;
    logic [3:0]      pos;
    logic [NPOS-1:0] exp_sel;
    logic [5:0]      cap_buf [NPOS];
    logic [NPOS-1:0] cap_bad;
    logic [5:0]      out_buf [NPOS];
    logic            commit_pend;

    seg14_char_decode u_decode (
        .segm (segm_q),
        .code (char_code)
    );

    assign char_unknown = (char_code == CODE_UNKNOWN);
    assign exp_sel      = FIRST_SEL << pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            segm_q <= '0;
        end else begin
            sel_q  <= sel;
            segm_q <= segm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            pos         <= '0;
            cap_bad     <= '0;
            commit_pend <= 1'b0;
            frame_valid <= 1'b0;
            frame_ovf   <= 1'b0;
            bad_char    <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            for (int i = 0; i < NPOS; i++) begin
                cap_buf[i] <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            seq_err     <= 1'b0;
            commit_pend <= 1'b0;

            // A pending commit beats a coinciding ack; the ack only clears the overflow.
            if (commit_pend) begin
                out_buf     <= cap_buf;
                bad_char    <= |cap_bad;
                frame_valid <= 1'b1;
                frame_ovf   <= ack ? 1'b0 : (frame_ovf | frame_valid);
            end else if (ack) begin
                frame_valid <= 1'b0;
                frame_ovf   <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (sel_q == FIRST_SEL) begin
                        state      <= CAPTURE;
                        locked     <= 1'b1;
                        cap_buf[0] <= char_code;
                        cap_bad[0] <= char_unknown;
                        pos        <= 4'd1;
                    end
                end
                CAPTURE: begin
                    if (sel_q == exp_sel) begin
                        cap_buf[pos] <= char_code;
                        cap_bad[pos] <= char_unknown;
                        if (pos == LAST_POS) begin
                            pos         <= '0;
                            commit_pend <= 1'b1;
                        end else begin
                            pos <= pos + 4'd1;
                        end
                    end else begin
                        seq_err <= 1'b1;
                        state   <= HUNT;
                        locked  <= 1'b0;
                        pos     <= '0;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                    pos    <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd_code = '0;
        if (rd_idx < 4'(NPOS)) begin
            rd_code = out_buf[rd_idx];
        end
    end

endmodule

// File: tb/tb_seg14_frame_decoder.sv
// Directed bench for seg14_frame_decoder: scan sequences with hand-computed codes.
module tb_seg14_frame_decoder;

    localparam logic [13:0] P_SP   = 14'b0000_0000_0000_00;
    localparam logic [13:0] P_A    = 14'b1110_1111_0000_00;
    localparam logic [13:0] P_C    = 14'b1001_1100_0000_00;
    localparam logic [13:0] P_H    = 14'b0110_1111_0000_00;
    localparam logic [13:0] P_M    = 14'b0110_1100_1010_00;
    localparam logic [13:0] P_O    = 14'b1111_1100_0000_00;
    localparam logic [13:0] P_S    = 14'b1011_0111_0000_00;
    localparam logic [13:0] P_Z    = 14'b1001_0000_0011_00;
    localparam logic [13:0] P_NT   = 14'b1110_1100_1000_01;
    localparam logic [13:0] P_0    = 14'b1111_1100_0011_00;
    localparam logic [13:0] P_5    = 14'b1001_0110_0000_01;
    localparam logic [13:0] P_9    = 14'b1111_0111_0000_00;
    localparam logic [13:0] P_ONES = 14'b1111_1111_1111_11;

    logic        clk;
    logic        rst_n;
    logic [11:0] sel;
    logic [13:0] segm;
    logic [3:0]  rd_idx;
    logic [5:0]  rd_code;
    logic        ack;
    logic        frame_valid;
    logic        frame_ovf;
    logic        bad_char;
    logic        seq_err;
    logic        locked;

    int vectors = 0;
    int miscompares = 0;
    int seq_cnt = 0;

    logic [13:0] pats  [3][12];
    int          codes [3][12];

    seg14_frame_decoder #(.NPOS(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .segm        (segm),
        .rd_idx      (rd_idx),
        .rd_code     (rd_code),
        .ack         (ack),
        .frame_valid (frame_valid),
        .frame_ovf   (frame_ovf),
        .bad_char    (bad_char),
        .seq_err     (seq_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (seq_err === 1'b1) seq_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_pos(input int p, input logic [13:0] pat);
        sel  = 12'(1) << p;
        segm = pat;
        step();
    endtask

    task automatic scan_range(input int fi, input int first, input int last);
        for (int p = first; p <= last; p++) scan_pos(p, pats[fi][p]);
    endtask

    task automatic idle(input int n);
        sel  = '0;
        segm = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_frame(input string tag, input int fi);
        for (int i = 0; i < 12; i++) begin
            rd_idx = 4'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_code), 32'(codes[fi][i]));
        end
        rd_idx = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pats[0]  = '{P_C, P_A, P_M, P_A, P_C, P_H, P_O, P_SP, P_SP, P_SP, P_SP, P_SP};
        codes[0] = '{3, 1, 13, 1, 3, 8, 15, 0, 0, 0, 0, 0};
        pats[1]  = '{P_S, P_5, P_0, P_9, P_NT, P_Z, P_A, P_H, P_C, P_M, P_O, P_SP};
        codes[1] = '{19, 33, 28, 37, 27, 26, 1, 8, 3, 13, 15, 0};
        pats[2]  = '{P_C, P_A, P_ONES, P_A, P_C, P_H, P_O, P_SP, P_SP, P_SP, P_SP, P_SP};
        codes[2] = '{3, 1, 63, 1, 3, 8, 15, 0, 0, 0, 0, 0};

        rst_n  = 1'b0;
        sel    = '0;
        segm   = '0;
        rd_idx = '0;
        ack    = 1'b0;

        // Reset state
        step();
        check("rst_valid",  32'(frame_valid), 0);
        check("rst_ovf",    32'(frame_ovf),   0);
        check("rst_bad",    32'(bad_char),    0);
        check("rst_seqerr", 32'(seq_err),     0);
        check("rst_locked", 32'(locked),      0);
        check("rst_rdcode", 32'(rd_code),     0);
        rst_n = 1'b1;
        step();

        // CAMACHO frame and commit latency
        scan_range(0, 0, 11);
        check("lat_edge1", 32'(frame_valid), 0);
        idle(1);
        check("lat_edge2", 32'(frame_valid), 0);
        idle(1);
        check("lat_edge3", 32'(frame_valid), 1);
        check("f1_bad", 32'(bad_char), 0);
        check("f1_ovf", 32'(frame_ovf), 0);
        check_frame("f1", 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("f1_ack_valid", 32'(frame_valid), 0);

        // Scan starting mid-frame is ignored while hunting
        seq_cnt = 0;
        for (int p = 5; p <= 11; p++) scan_pos(p, P_A);
        scan_pos(0, pats[1][0]);
        check("hunt_no_seqerr", 32'(seq_cnt), 0);
        check("hunt_not_locked", 32'(locked), 0);
        scan_pos(1, pats[1][1]);
        check("hunt_locked", 32'(locked), 1);
        scan_range(1, 2, 11);
        idle(2);
        check("f2_valid", 32'(frame_valid), 1);
        check("f2_ovf", 32'(frame_ovf), 0);
        check("f2_bad", 32'(bad_char), 0);
        check_frame("f2", 1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Multi-hot select at position 3
        seq_cnt = 0;
        scan_range(0, 0, 2);
        sel  = 12'b000000001100;
        segm = P_A;
        step();
        idle(3);
        check("multihot_seqerr", 32'(seq_cnt), 1);
        check("multihot_locked", 32'(locked), 0);
        check("multihot_nocommit", 32'(frame_valid), 0);

        // Back-to-back frames without ack overflow
        scan_range(0, 0, 11);
        scan_range(1, 0, 11);
        idle(2);
        check("b2b_valid", 32'(frame_valid), 1);
        check("b2b_ovf", 32'(frame_ovf), 1);
        check_frame("b2b", 1);

        // Third frame: unknown pattern, ack on its commit edge
        scan_range(2, 0, 11);
        idle(1);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        check("ackcommit_valid", 32'(frame_valid), 1);
        check("ackcommit_ovf", 32'(frame_ovf), 0);
        check("f3_bad", 32'(bad_char), 1);
        check_frame("f3", 2);
        rd_idx = 4'd13;
        #1;
        check("rd_idx13", 32'(rd_code), 0);
        rd_idx = 4'd12;
        #1;
        check("rd_idx12", 32'(rd_code), 0);
        rd_idx = 4'd0;

        // Reset mid-frame at position 6
        scan_range(1, 0, 5);
        sel  = 12'(1) << 6;
        segm = pats[1][6];
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",  32'(frame_valid), 0);
        check("midrst_ovf",    32'(frame_ovf),   0);
        check("midrst_bad",    32'(bad_char),    0);
        check("midrst_seqerr", 32'(seq_err),     0);
        check("midrst_locked", 32'(locked),      0);
        check("midrst_rdcode", 32'(rd_code),     0);
        step();
        #2;
        rst_n = 1'b1;
        step();
        scan_range(1, 7, 11);
        idle(3);
        check("postrst_nocommit", 32'(frame_valid), 0);
        scan_range(1, 0, 11);
        idle(2);
        check("postrst_valid", 32'(frame_valid), 1);
        check("postrst_ovf", 32'(frame_ovf), 0);
        check("postrst_bad", 32'(bad_char), 0);
        check_frame("postrst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
